bin_stim_gen: RTL

//  Synthesizable stimulus sequencer for the universal N-bit binary counter. Drives
//  syn_clr/load/en/up/d into the counter and its self-checking monitor. Runs a fixed

---
 rtl/bin_stim_gen_pkg.sv | 35 +++
 rtl/bin_stim_gen_if.sv | 26 ++
 rtl/bin_stim_gen_lfsr8.sv | 17 +
 rtl/bin_stim_gen.sv | 92 +++++++++
 4 files changed

// File: rtl/bin_stim_gen_pkg.sv
// bin_stim_pkg: state encoding, LFSR feedback taps and sizing helpers shared by the stimulus sequencer.
package bin_stim_pkg;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_CLR  = 3'd1,
        S_LOAD = 3'd2,
        S_UP   = 3'd3,
        S_DOWN = 3'd4,
        S_HOLD = 3'd5,
        S_RAND = 3'd6,
        S_DONE = 3'd7
    } state_e;

    // x^8 + x^6 + x^5 + x^4 + 1 as bit positions 7, 5, 4, 3 of a left-shifting register
    localparam logic [7:0] LFSR_TAPS = 8'b1011_1000;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = a > b ? a : b;
        return m > c ? m : c;
    endfunction

    function automatic logic [7:0] lfsr_next(input logic [7:0] q);
        return {q[6:0], ^(q & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/bin_stim_gen_if.sv
// bin_stim_gen_if: control, tick and status signals between the stimulus sequencer and the counter under test.
interface bin_stim_gen_if #(
    parameter int N = 3
);
    logic         start;
    logic         max_tick;
    logic         min_tick;
    logic         syn_clr;
    logic         load;
    logic         en;
    logic         up;
    logic [N-1:0] d;
    logic         busy;
    logic         done;
    logic [7:0]   wrap_cnt;

    modport master (
        input  start, max_tick, min_tick,
        output syn_clr, load, en, up, d, busy, done, wrap_cnt
    );

    modport slave (
        output start, max_tick, min_tick,
        input  syn_clr, load, en, up, d, busy, done, wrap_cnt
    );
endinterface

// File: rtl/bin_stim_gen_lfsr8.sv
// lfsr8: 8-bit Fibonacci LFSR that advances only while en is high; active-low synchronous reset to seed.
module lfsr8
    import bin_stim_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic [7:0] seed,
    output logic [7:0] q
);

    always_ff @(posedge clk) begin
        if (!reset) q <= seed;
        else if (en) q <= lfsr_next(q);
    end

endmodule

// File: rtl/bin_stim_gen.sv
// bin_stim_gen: directed-then-random stimulus sequencer for an N-bit up/down counter, counting wrap events.
module bin_stim_gen
    import bin_stim_pkg::*;
#(
    parameter int           N        = 3,
    parameter logic [N-1:0] LOAD_VAL = 3'b101,
    parameter int           HOLD     = 4,
    parameter int           RAND_LEN = 16,
    parameter logic [7:0]   SEED     = 8'hA5
) (
    input logic            clk,
    input logic            reset,
    bin_stim_gen_if.master bus
);

    localparam int SWEEP = (1 << N) + 1;
    localparam int W     = clog2(max3(SWEEP, HOLD, RAND_LEN)) + 1;

    state_e         state_q, state_d;
    logic [W-1:0]   cnt_q, cnt_d;
    logic           syn_clr_q, syn_clr_d;
    logic           load_q, load_d;
    logic           en_q, en_d;
    logic           up_q, up_d;
    logic [N-1:0]   d_q, d_d;
    logic [7:0]     wrap_q, wrap_d;
    logic [7:0]     lfsr_q, lfsr_d;
    logic           rand_clr;

    lfsr8 u_lfsr (
        .clk   (clk),
        .reset (reset),
        .en    (state_q == S_RAND),
        .seed  (SEED),
        .q     (lfsr_q)
    );

    function automatic logic [W-1:0] phase_last(input state_e s);
        return (s == S_UP || s == S_DOWN) ? W'(SWEEP - 1) :
               (s == S_HOLD)              ? W'(HOLD - 1)  :
               (s == S_RAND)              ? W'(RAND_LEN - 1) : '0;
    endfunction

    always_comb begin
        state_d = state_q;
        if (state_q == S_IDLE) state_d = bus.start ? S_CLR : S_IDLE;
        // states are numbered in sequence order; DONE+1 wraps to IDLE
        else if (cnt_q == '0) state_d = state_e'(state_q + 3'd1);
        cnt_d     = (state_d != state_q) ? phase_last(state_d) : (cnt_q == '0 ? '0 : cnt_q - 1'b1);
        // outputs are registered, so use the LFSR value that will be present next cycle
        lfsr_d    = (state_q == S_RAND) ? lfsr_next(lfsr_q) : lfsr_q;
        rand_clr  = &lfsr_d[7:5];
        syn_clr_d = state_d == S_CLR || (state_d == S_RAND && rand_clr);
        load_d    = state_d == S_LOAD || (state_d == S_RAND && lfsr_d[4] && lfsr_d[3] && !rand_clr);
        en_d      = state_d == S_UP || state_d == S_DOWN || (state_d == S_RAND && lfsr_d[2]);
        up_d      = state_d == S_UP || (state_d == S_RAND && lfsr_d[1]);
        d_d       = (state_d == S_LOAD) ? LOAD_VAL : (state_d == S_RAND) ? lfsr_d[N-1:0] : '0;
        wrap_d    = wrap_q + 8'(wrap_q != 8'hFF && en_q && (up_q ? bus.max_tick : bus.min_tick));
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            syn_clr_q <= 1'b0;
            load_q    <= 1'b0;
            en_q      <= 1'b0;
            up_q      <= 1'b0;
            d_q       <= '0;
            wrap_q    <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            syn_clr_q <= syn_clr_d;
            load_q    <= load_d;
            en_q      <= en_d;
            up_q      <= up_d;
            d_q       <= d_d;
            wrap_q    <= wrap_d;
        end
    end

    assign bus.syn_clr  = syn_clr_q;
    assign bus.load     = load_q;
    assign bus.en       = en_q;
    assign bus.up       = up_q;
    assign bus.d        = d_q;
    assign bus.busy     = state_q != S_IDLE;
    assign bus.done     = state_q == S_DONE;
    assign bus.wrap_cnt = wrap_q;

endmodule
